// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU,
// one quotient bit per cycle, valid/ready handshakes on both sides.
module alu_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  op_signed,
    input  logic                  op_rem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic          op_rem_q, op_rem_d, dbz_q, dbz_d;

    logic          a_neg, b_neg, b_zero, ovf, qbit;
    logic [W-1:0]  a_mag, b_mag, rem_nx, quo_nx;
    logic [W:0]    shifted, diff;

    // a_q doubles as the dividend shifter and the quotient accumulator
    always_comb begin
        a_neg     = op_signed & in_a[W-1];
        b_neg     = op_signed & in_b[W-1];
        a_mag     = a_neg ? -in_a : in_a;
        b_mag     = b_neg ? -in_b : in_b;
        b_zero    = in_b == '0;
        ovf       = op_signed && in_a == {1'b1, {(W-1){1'b0}}} && &in_b;
        shifted   = {rem_q, a_q[W-1]};
        diff      = shifted - {1'b0, b_q};
        qbit      = ~diff[W];
        rem_nx    = qbit ? diff[W-1:0] : shifted[W-1:0];
        quo_nx    = {a_q[W-2:0], qbit};
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_rem_d  = op_rem_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        if (state_q == IDLE && in_valid) begin
            if (b_zero) begin
                state_d  = DONE;
                result_d = op_rem ? in_a : '1;
                dbz_d    = 1'b1;
            end else if (ovf) begin
                state_d  = DONE;
                result_d = op_rem ? '0 : in_a;
                dbz_d    = 1'b0;
            end else begin
                state_d   = CALC;
                a_d       = a_mag;
                b_d       = b_mag;
                rem_d     = '0;
                cnt_d     = CNT_MAX;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                op_rem_d  = op_rem;
            end
        end else if (state_q == CALC) begin
            a_d   = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d  = DONE;
                result_d = op_rem_q ? (neg_rem_q ? -rem_nx : rem_nx)
                                    : (neg_quo_q ? -quo_nx : quo_nx);
                dbz_d    = 1'b0;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_rem_q  <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_rem_q  <= op_rem_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = state_q == DONE;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
endmodule
